// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the PC register, keeps at most one imem request
// in flight and buffers fetched {pc, instr} pairs in an in-order queue for decode.
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_cur,
  output logic             pc_write_en,
  output logic [31:0]      pc_next,
  output logic             imem_req_valid,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             fq_valid,
  output logic [31:0]      fq_pc,
  output logic [31:0]      fq_instr,
  input  logic             fq_ready,
  output logic [CNT_W-1:0] fq_count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RESP = 2'd1;
  localparam logic [1:0] DROP      = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic        req_valid;
  logic        pc_we;
  logic [31:0] pc_nx;
  logic        push;
  logic        pop;
  logic        unused_redirect_lsbs;

  assign imem_req_addr        = {pc_cur[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    req_valid = 1'b0;
    pc_we     = 1'b0;
    pc_nx     = 32'h0;
    push      = 1'b0;

    case (state_q)
      IDLE: begin
        req_valid = !redirect_valid && (count_q < FULL_CNT);
        if (req_valid && imem_req_ready) begin
          pc_we    = 1'b1;
          pc_nx    = pc_cur + 32'd4;
          req_pc_d = imem_req_addr;
          state_d  = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (imem_resp_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides the PC write and kills the response of an outstanding request
    if (redirect_valid) begin
      pc_we = 1'b1;
      pc_nx = {redirect_pc[31:2], 2'b00};
      push  = 1'b0;
      if (state_q != IDLE) state_d = imem_resp_valid ? IDLE : DROP;
    end
  end

  assign imem_req_valid = req_valid & ~rst;
  assign pc_write_en    = pc_we & ~rst;
  assign pc_next        = rst ? 32'h0 : pc_nx;

  assign fq_valid = (count_q != '0);
  assign fq_pc    = fq_valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign fq_instr = fq_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign fq_count = count_q;
  assign pop      = fq_valid & fq_ready & ~redirect_valid;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_pc_q <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: queue storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic, all
// compared every cycle against a queue-based reference model of the fetch front end.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [31:0]      pc_cur;
  logic             pc_write_en;
  logic [31:0]      pc_next;
  logic             imem_req_valid;
  logic [31:0]      imem_req_addr;
  logic             imem_req_ready;
  logic             imem_resp_valid;
  logic [31:0]      imem_resp_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             fq_valid;
  logic [31:0]      fq_pc;
  logic [31:0]      fq_instr;
  logic             fq_ready;
  logic [CNT_W-1:0] fq_count;

  fetch_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_write_en     (pc_write_en),
    .pc_next         (pc_next),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fq_valid        (fq_valid),
    .fq_pc           (fq_pc),
    .fq_instr        (fq_instr),
    .fq_ready        (fq_ready),
    .fq_count        (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: PC register, one outstanding fetch, queue of {pc, instr}
  logic [31:0] pc_reg;
  logic [63:0] m_q[$];
  bit          m_out;
  bit          m_discard;
  logic [31:0] m_pc;

  // Memory responder and stimulus knobs
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_data;
  bit          ready_cfg, pop_cfg, spur_cfg, data_fix;
  int          lat_cfg;
  logic [31:0] data_val;

  // Observations of DUT handshakes, compared against fixed expectations
  int          hs_count;
  logic [31:0] last_hs_addr;
  logic [31:0] wrap_next;

  assign pc_cur = pc_reg;

  task automatic check_reset(input string pfx);
    check({pfx, "_req_valid"}, imem_req_valid, 0);
    check({pfx, "_req_addr"},  imem_req_addr,  0);
    check({pfx, "_pc_we"},     pc_write_en,    0);
    check({pfx, "_pc_next"},   pc_next,        0);
    check({pfx, "_fq_valid"},  fq_valid,       0);
    check({pfx, "_fq_count"},  fq_count,       0);
    check({pfx, "_fq_pc"},     fq_pc,          0);
    check({pfx, "_fq_instr"},  fq_instr,       0);
  endtask

  // One clock cycle: entered and left at the falling edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit          resp, spur, exp_rv, exp_hs, hs_act;
    logic [31:0] rdata;
    logic [63:0] head;
    spur     = spur_cfg && !mem_busy && !m_out;
    spur_cfg = 1'b0;
    resp     = (mem_busy && mem_delay == 0) || spur;
    rdata    = spur ? $urandom() : mem_data;
    imem_resp_valid = resp;
    imem_resp_data  = rdata;
    imem_req_ready  = ready_cfg;
    fq_ready        = pop_cfg;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    #1;
    exp_rv = !m_out && !redir && (m_q.size() < DEPTH);
    exp_hs = exp_rv && ready_cfg;
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, pc_reg & 32'hFFFF_FFFC);
    check("pc_write_en", pc_write_en, redir || exp_hs);
    if (redir)       check("pc_next_redirect", pc_next, rpc & 32'hFFFF_FFFC);
    else if (exp_hs) check("pc_next_incr", pc_next, pc_reg + 32'd4);
    check("fq_valid", fq_valid, m_q.size() != 0);
    check("fq_count", fq_count, m_q.size());
    if (m_q.size() != 0) begin
      head = m_q[0];
      check("fq_pc", fq_pc, head[63:32]);
      check("fq_instr", fq_instr, head[31:0]);
    end
    hs_act = imem_req_valid && imem_req_ready;
    if (hs_act) begin
      hs_count++;
      last_hs_addr = imem_req_addr;
      if (imem_req_addr == 32'hFFFF_FFFC) wrap_next = pc_next;
    end

    @(posedge clk);
    #1;
    if (redir) begin
      m_q.delete();
      if (m_out) begin
        if (resp) m_out = 1'b0;
        else      m_discard = 1'b1;
      end
      pc_reg = rpc & 32'hFFFF_FFFC;
    end else begin
      if (m_q.size() != 0 && pop_cfg) head = m_q.pop_front();
      if (m_out && resp) begin
        if (!m_discard) m_q.push_back({m_pc, rdata});
        m_out = 1'b0;
      end
      if (exp_hs) begin
        m_out     = 1'b1;
        m_discard = 1'b0;
        m_pc      = pc_reg & 32'hFFFF_FFFC;
        pc_reg    = pc_reg + 32'd4;
      end
    end

    if (resp && !spur)  mem_busy = 1'b0;
    else if (mem_busy)  mem_delay--;
    if (hs_act) begin
      mem_busy  = 1'b1;
      mem_delay = (lat_cfg == 0) ? int'($urandom_range(4, 1)) - 1 : lat_cfg - 1;
      mem_data  = data_fix ? data_val : $urandom();
    end
    @(negedge clk);
  endtask

  task automatic do_reset_mid();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    fq_ready        = 1'b0;
    rst       = 1'b1;
    pc_reg    = 32'h0;
    m_q.delete();
    m_out     = 1'b0;
    m_discard = 1'b0;
    #1;
    check_reset("mid_rst");
    @(posedge clk);
    #1;
    check_reset("mid_rst_edge");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pc_reg = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; fq_ready = 1'b0;
    m_out = 1'b0; m_discard = 1'b0; m_pc = 32'h0;
    mem_busy = 1'b0; mem_delay = 0; mem_data = 32'h0;
    spur_cfg = 1'b0; hs_count = 0; last_hs_addr = 32'hFFFF_FFFF; wrap_next = 32'hDEAD_0000;

    #1;
    check_reset("rst");
    @(posedge clk);
    #1;
    check_reset("rst_edge");
    @(negedge clk);
    rst = 1'b0;

    // Steady fetch: one request every two cycles, data 0x13
    ready_cfg = 1'b1; pop_cfg = 1'b1; lat_cfg = 1; data_fix = 1'b1; data_val = 32'h0000_0013;
    repeat (10) cycle(1'b0, 32'h0);
    check("basic_hs_count", hs_count, 5);
    check("basic_last_addr", last_hs_addr, 32'h10);

    // Fill the queue with decode stalled
    pop_cfg = 1'b0; data_fix = 1'b0;
    repeat (12) cycle(1'b0, 32'h0);
    check("full_count", fq_count, 4);
    check("full_req_valid", imem_req_valid, 0);
    hs_count = 0;
    pop_cfg = 1'b1;
    cycle(1'b0, 32'h0);
    pop_cfg = 1'b0;
    repeat (7) cycle(1'b0, 32'h0);
    check("one_pop_one_req", hs_count, 1);
    check("refill_count", fq_count, 4);

    // Redirect while waiting; late 0xDEADBEEF response must be dropped
    pop_cfg = 1'b1; ready_cfg = 1'b0;
    repeat (2) cycle(1'b0, 32'h0);
    pop_cfg = 1'b0; ready_cfg = 1'b1; lat_cfg = 4; data_fix = 1'b1; data_val = 32'hDEAD_BEEF;
    for (int n = 0; n < 20 && !m_out; n++) cycle(1'b0, 32'h0);
    check("reach_wait_resp", m_out, 1);
    cycle(1'b1, 32'h0000_0100);
    check("redir_flush_count", fq_count, 0);
    check("redir_flush_valid", fq_valid, 0);
    hs_count = 0;
    repeat (3) cycle(1'b0, 32'h0);
    check("drop_not_enqueued", fq_count, 0);
    repeat (5) cycle(1'b0, 32'h0);
    check("redir_next_addr", last_hs_addr, 32'h100);
    check("redir_single_req", hs_count, 1);

    // Redirect coinciding with the response
    pop_cfg = 1'b1; lat_cfg = 2; data_fix = 1'b0;
    for (int n = 0; n < 20 && !m_out; n++) cycle(1'b0, 32'h0);
    check("reach_wait_resp2", m_out, 1);
    cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0203);
    check("redir_resp_count", fq_count, 0);
    hs_count = 0;
    cycle(1'b0, 32'h0);
    check("redir_resp_idle_req", hs_count, 1);
    check("redir_resp_addr", last_hs_addr, 32'h200);

    // PC wrap at the top of the address space
    cycle(1'b1, 32'hFFFF_FFFE);
    repeat (8) cycle(1'b0, 32'h0);
    check("wrap_pc_next", wrap_next, 32'h0);

    // Push and pop together at count 2, then reset while waiting
    ready_cfg = 1'b0;
    repeat (6) cycle(1'b0, 32'h0);
    ready_cfg = 1'b1; pop_cfg = 1'b0; lat_cfg = 1;
    for (int n = 0; n < 20 && !(m_q.size() == 2 && m_out); n++) cycle(1'b0, 32'h0);
    check("reach_count2_wait", m_q.size() == 2 && m_out, 1);
    pop_cfg = 1'b1;
    cycle(1'b0, 32'h0);
    pop_cfg = 1'b0;
    check("push_pop_count", fq_count, 2);
    lat_cfg = 3;
    for (int n = 0; n < 20 && !m_out; n++) cycle(1'b0, 32'h0);
    check("reach_wait_rst", m_out, 1);
    cycle(1'b0, 32'h0);
    do_reset_mid();
    ready_cfg = 1'b0;
    repeat (5) cycle(1'b0, 32'h0);
    check("late_resp_ignored", fq_count, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      ready_cfg = ($urandom_range(3, 0) != 0);
      pop_cfg   = $urandom_range(1, 0) != 0;
      lat_cfg   = 0;
      data_fix  = 1'b0;
      spur_cfg  = ($urandom_range(31, 0) == 0);
      if ($urandom_range(15, 0) == 0) cycle(1'b1, $urandom());
      else                            cycle(1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
